tlc_input_conditioner: RTL
==========================

# tlc_input_conditioner

Front-end conditioning stage for the traffic light controller. It divides the board clock into aligned 100 Hz and 1 Hz single-cycle strobes, and synchronises and debounces the raw `standby` and `test` switches. It also holds the controller in standby for a fixed boot interval after reset. All outputs feed the controller directly: strobes replace its internal dividers, and the conditioned levels replace its raw switch inputs.

## Interface
- `CLK_HZ`, default 1_000_000: board clock frequency; must be a multiple of 100.
- `DB_TICKS`, default 3: consecutive differing 100 Hz samples required to accept a switch change (range 1..15).
- `BOOT_S`, default 2: seconds of forced standby after reset (range 0..15).
- `clk`  in  1  board clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `standby_raw`  in  1  raw standby switch, asynchronous to `clk`.
- `test_raw`  in  1  raw test switch, asynchronous to `clk`.
- `tick_100hz`  out  1  one-cycle strobe every CLK_HZ/100 clocks.
- `tick_1hz`  out  1  one-cycle strobe every CLK_HZ clocks; always coincident with a `tick_100hz`.
- `scan_phase`  out  1  50 Hz square wave; toggles on each `tick_100hz`; drives the display mux select.
- `standby_o`  out  1  conditioned standby level to the controller; forced to 1 during boot.
- `test_o`  out  1  debounced test level.
- `test_rise`  out  1  one-cycle pulse on each 0→1 transition of `test_o`.

## Operation
- **Prescaler**
  - `pre_cnt` runs 0..CLK_HZ/100-1 and wraps.
  - `tick_100hz` is 1 on the cycle where `pre_cnt` equals the terminal value.
  - `sec_cnt` runs 0..99 and advances only on `tick_100hz`.
  - `tick_1hz` = `tick_100hz` && `sec_cnt`==99.
- **Synchroniser:** each raw input passes through a 2-flop synchroniser with reset value 0.
- **Debouncer:** one instance per input.
  - Sampling happens only on `tick_100hz`.
  - Sample ≠ current stable value → `db_cnt`++.
  - Sample == stable value → `db_cnt` clears to 0.
  - When `db_cnt` reaches DB_TICKS: stable takes the sample and `db_cnt` clears.
  - A glitch shorter than DB_TICKS samples never changes stable.
- **Boot FSM**, states BOOT and RUN:
  - Reset enters BOOT.
  - BOOT: `standby_o`=1 and `boot_cnt` increments on `tick_1hz`. When `boot_cnt`==BOOT_S, transition to RUN.
  - RUN: `standby_o` = debounced standby.
  - BOOT_S=0: the first clock after reset release moves to RUN.
  - RUN is terminal until the next reset.
- **test_rise:** registered edge detect on `test_o`. It is also active in BOOT, because the controller ignores it while in standby.
- **Reset values**
  - `tick_100hz`, `tick_1hz`, `scan_phase`, `test_o`, `test_rise` = 0; `standby_o` = 1.
  - All counters = 0; debouncer stable values = 0.
- **Reset mid-operation:** all state clears asynchronously, and the boot hold restarts in full.

## Timing
- First `tick_100hz` occurs on cycle CLK_HZ/100 after reset release (cycle index CLK_HZ/100-1 counting from 0). First `tick_1hz` occurs on cycle CLK_HZ.
- Switch latency:
  - 2 clocks of synchronisation, then
  - wait until the DB_TICKS-th `tick_100hz` after the synchronised change, then
  - the output updates on the clock after that tick.
- `test_rise` asserts one clock after `test_o` rises, for exactly 1 cycle.
- `standby_o` deasserts on the clock after the `tick_1hz` that makes `boot_cnt`==BOOT_S, provided debounced standby is 0.
- A raw change landing on a tick cycle is seen on a later tick, because it is counted only after synchronisation.

## Structure
- Shared package `tlc_pkg` holds:
  - the boot FSM state enum (BOOT, RUN);
  - the constant `TICKS_PER_SEC`=100;
  - the `CLK_HZ` default.
- One natural sub-module: `tlc_debounce` (synchroniser + counter + stable register, tick-enabled), instantiated twice.
- Prescaler, boot FSM and edge detect stay in the top module.

## Test plan
Use CLK_HZ=1000 (so CLK_HZ/100=10), DB_TICKS=3, BOOT_S=2 unless stated otherwise.
1. **Prescaler:** release reset, run 2500 clocks → `tick_100hz` at cycles 10, 20, …; `tick_1hz` at cycles 1000 and 2000, each coincident with a `tick_100hz`; `scan_phase` toggles every 10 clocks.
2. **Boot hold:** `standby_raw`=0 throughout → `standby_o`=1 until the clock after the cycle-2000 `tick_1hz`, then 0 permanently.
3. **Glitch rejection:** after boot, pulse `test_raw` high for 15 clocks (spans only 1–2 ticks) → `test_o` and `test_rise` stay 0.
4. **Clean press:** hold `test_raw`=1 → `test_o` rises exactly one clock after the 3rd tick following synchronisation; `test_rise` is high for exactly 1 cycle, one clock after `test_o` rises. Release the switch → `test_o` falls after the same latency, and no pulse occurs.
5. **Standby in RUN:** hold `standby_raw`=1 → `standby_o` rises after the debounce latency. Release → it falls after the same latency.
6. **Reset mid-RUN:** assert `rst_n`=0 for 1 clock while `test_o`=1 → all outputs return to reset values immediately; `standby_o`=1 again for a full 2 s boot interval.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller front end.
// Boot FSM states and timing constants.
package tlc_pkg;

    localparam int TICKS_PER_SEC = 100;
    localparam int CLK_HZ_DEF    = 1_000_000;

    typedef enum logic {
        BOOT,
        RUN
    } boot_state_t;

endpackage

// File: rtl/tlc_input_conditioner_if.sv
// Conditioner <-> board/controller bundle.
// The master drives strobes and conditioned levels; the slave owns the raw switches.
interface tlc_input_conditioner_if;
    import tlc_pkg::*;

    logic standby_raw;
    logic test_raw;
    logic tick_100hz;
    logic tick_1hz;
    logic scan_phase;
    logic standby_o;
    logic test_o;
    logic test_rise;

    modport master (
        input  standby_raw,
        input  test_raw,
        output tick_100hz,
        output tick_1hz,
        output scan_phase,
        output standby_o,
        output test_o,
        output test_rise
    );

    modport slave (
        output standby_raw,
        output test_raw,
        input  tick_100hz,
        input  tick_1hz,
        input  scan_phase,
        input  standby_o,
        input  test_o,
        input  test_rise
    );

endinterface

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser followed by a tick-sampled debounce counter.
// The stable level only moves after DB_TICKS consecutive differing samples.
module tlc_debounce
    import tlc_pkg::*;
#(
    parameter int DB_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    logic       s1;
    logic       s2;
    logic [3:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (tick) begin
                if (s2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == 4'(DB_TICKS - 1)) begin
                    stable <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tlc_input_conditioner.sv
// Prescaler, switch conditioning and boot standby hold for the
// traffic light controller.
module tlc_input_conditioner
    import tlc_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEF,
    parameter int DB_TICKS = 3,
    parameter int BOOT_S   = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    tlc_input_conditioner_if.master  bus
);

    localparam int DIV = CLK_HZ / TICKS_PER_SEC;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic [6:0]    sec_cnt;
    logic          t100;
    logic          t1;
    logic          scan_q;

    boot_state_t   state;
    logic [3:0]    boot_cnt;
    logic          hold;

    logic          db_sb;
    logic          db_test;
    logic          test_q;
    logic          rise_q;

    assign t100 = (pre_cnt == PW'(DIV - 1));
    assign t1   = t100 && (sec_cnt == 7'd99);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            sec_cnt <= '0;
            scan_q  <= 1'b0;
        end else begin
            pre_cnt <= t100 ? '0 : pre_cnt + PW'(1);
            if (t100) begin
                sec_cnt <= (sec_cnt == 7'd99) ? 7'd0 : sec_cnt + 7'd1;
                scan_q  <= ~scan_q;
            end
        end
    end

    tlc_debounce #(.DB_TICKS(DB_TICKS)) u_db_standby (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (t100),
        .raw    (bus.standby_raw),
        .stable (db_sb)
    );

    tlc_debounce #(.DB_TICKS(DB_TICKS)) u_db_test (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (t100),
        .raw    (bus.test_raw),
        .stable (db_test)
    );

    // hold releases on the same edge that moves to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
            hold     <= 1'b1;
        end else begin
            unique case (state)
                BOOT: begin
                    if (boot_cnt == 4'(BOOT_S)) begin
                        state <= RUN;
                        hold  <= 1'b0;
                    end else if (t1) begin
                        boot_cnt <= boot_cnt + 4'd1;
                        if (boot_cnt + 4'd1 == 4'(BOOT_S)) begin
                            state <= RUN;
                            hold  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            test_q <= db_test;
            rise_q <= db_test & ~test_q;
        end
    end

    assign bus.tick_100hz = t100;
    assign bus.tick_1hz   = t1;
    assign bus.scan_phase = scan_q;
    assign bus.standby_o  = hold | db_sb;
    assign bus.test_o     = db_test;
    assign bus.test_rise  = rise_q;

endmodule
